// File: rtl/icon_fetch_scheduler.sv
// Icon fetch scheduler: hit-tests a pixel against NUM_SLOTS icon slots and fetches its RGB bytes from the ROM.
// Optional feature macro TRANSPARENCY_EN: magenta (24'hFF00FF) icon pixels show the background colour.
module icon_fetch_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int NUM_ICONS = 8,
    parameter int ICON_W    = 48,
    parameter int ICON_H    = 48,
    parameter int ROM_AW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_req,
    output logic                         pix_ready,
    input  logic [9:0]                   x,
    input  logic [9:0]                   y,
    input  logic [23:0]                  bg_rgb,
    output logic                         out_valid,
    output logic [7:0]                   red,
    output logic [7:0]                   green,
    output logic [7:0]                   blue,
    output logic                         out_hit,
    output logic [$clog2(NUM_SLOTS)-1:0] out_slot,
    output logic                         rom_rd,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [7:0]                   rom_data,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
    input  logic                         cfg_en,
    input  logic [9:0]                   cfg_x,
    input  logic [9:0]                   cfg_y,
    input  logic [$clog2(NUM_ICONS)-1:0] cfg_icon,
    input  logic                         cfg_commit,
    output logic                         cfg_pending
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int IW = $clog2(NUM_ICONS);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CALC = 3'd1;
    localparam logic [2:0] RD_R = 3'd2;
    localparam logic [2:0] RD_G = 3'd3;
    localparam logic [2:0] RD_B = 3'd4;
    localparam logic [2:0] LAST = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    logic [2:0]    state;
    logic [9:0]    xq, yq;
    logic [7:0]    r_tmp, g_tmp;
    logic [SW-1:0] slot_q;
    logic          pending;
`ifdef TRANSPARENCY_EN
    logic [23:0]   bg_q;
`endif

    logic          sh_en   [NUM_SLOTS];
    logic [9:0]    sh_x    [NUM_SLOTS];
    logic [9:0]    sh_y    [NUM_SLOTS];
    logic [IW-1:0] sh_icon [NUM_SLOTS];
    logic          act_en  [NUM_SLOTS];
    logic [9:0]    act_x   [NUM_SLOTS];
    logic [9:0]    act_y   [NUM_SLOTS];
    logic [IW-1:0] act_icon[NUM_SLOTS];

    logic [NUM_SLOTS-1:0] slot_hit;
    logic                 hit_any;
    logic [SW-1:0]        hit_idx;
    logic [31:0]          base_full;
    logic                 copy;

    assign pix_ready   = (state == IDLE);
    assign cfg_pending = pending;
    assign copy        = (state == IDLE) && (pending || cfg_commit);

    // Window compares are done at 11 bits so sx+ICON_W near the right edge cannot wrap.
    always_comb begin
        slot_hit = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_hit[s] = act_en[s]
                && ({1'b0, xq} >= {1'b0, act_x[s]})
                && ({1'b0, xq} <  ({1'b0, act_x[s]} + 11'(ICON_W)))
                && ({1'b0, yq} >= {1'b0, act_y[s]})
                && ({1'b0, yq} <  ({1'b0, act_y[s]} + 11'(ICON_H)));
        end
    end

    // Scanning downward leaves the lowest-index hit as the final assignment.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        base_full = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                hit_any   = 1'b1;
                hit_idx   = SW'(s);
                base_full = 32'(act_icon[s]) * 32'(ICON_W * ICON_H * 3)
                          + (32'(yq - act_y[s]) * 32'(ICON_W) + 32'(xq - act_x[s])) * 32'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            xq        <= '0;
            yq        <= '0;
            r_tmp     <= '0;
            g_tmp     <= '0;
            slot_q    <= '0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_slot  <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
`ifdef TRANSPARENCY_EN
            bg_q      <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix_req) begin
                        xq    <= x;
                        yq    <= y;
                        state <= CALC;
                    end
                end
                CALC: begin
`ifdef TRANSPARENCY_EN
                    bg_q <= bg_rgb;
`endif
                    if (hit_any) begin
                        slot_q   <= hit_idx;
                        rom_rd   <= 1'b1;
                        rom_addr <= base_full[ROM_AW-1:0];
                        state    <= RD_R;
                    end else begin
                        {red, green, blue} <= bg_rgb;
                        out_hit   <= 1'b0;
                        out_slot  <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                RD_R: begin
                    rom_addr <= rom_addr + ROM_AW'(1);
                    state    <= RD_G;
                end
                RD_G: begin
                    r_tmp    <= rom_data;
                    rom_addr <= rom_addr + ROM_AW'(1);
                    state    <= RD_B;
                end
                RD_B: begin
                    g_tmp  <= rom_data;
                    rom_rd <= 1'b0;
                    state  <= LAST;
                end
                LAST: begin
                    // Results are staged so the outputs only change together with out_valid.
`ifdef TRANSPARENCY_EN
                    if ({r_tmp, g_tmp, rom_data} == 24'hFF00FF) begin
                        {red, green, blue} <= bg_q;
                        out_hit <= 1'b0;
                    end else begin
                        {red, green, blue} <= {r_tmp, g_tmp, rom_data};
                        out_hit <= 1'b1;
                    end
`else
                    {red, green, blue} <= {r_tmp, g_tmp, rom_data};
                    out_hit <= 1'b1;
`endif
                    out_slot  <= slot_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The copy samples the shadow bank before any same-cycle cfg_we lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                sh_en[s]    <= 1'b0;
                sh_x[s]     <= '0;
                sh_y[s]     <= '0;
                sh_icon[s]  <= '0;
                act_en[s]   <= 1'b0;
                act_x[s]    <= '0;
                act_y[s]    <= '0;
                act_icon[s] <= '0;
            end
        end else begin
            if (copy) begin
                pending <= 1'b0;
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    act_en[s]   <= sh_en[s];
                    act_x[s]    <= sh_x[s];
                    act_y[s]    <= sh_y[s];
                    act_icon[s] <= sh_icon[s];
                end
            end else if (cfg_commit) begin
                pending <= 1'b1;
            end
            if (cfg_we) begin
                sh_en[cfg_slot]   <= cfg_en;
                sh_x[cfg_slot]    <= cfg_x;
                sh_y[cfg_slot]    <= cfg_y;
                sh_icon[cfg_slot] <= cfg_icon;
            end
        end
    end
endmodule

// File: tb/tb_icon_fetch_scheduler.sv
// Self-checking bench for icon_fetch_scheduler: directed steps plus randomized requests against a slot-table model.
module tb_icon_fetch_scheduler;
    logic        clk;
    logic        rst;
    logic        pix_req;
    logic        pix_ready;
    logic [9:0]  x, y;
    logic [23:0] bg_rgb;
    logic        out_valid;
    logic [7:0]  red, green, blue;
    logic        out_hit;
    logic [1:0]  out_slot;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic        cfg_en;
    logic [9:0]  cfg_x, cfg_y;
    logic [2:0]  cfg_icon;
    logic        cfg_commit;
    logic        cfg_pending;

    int checks = 0;
    int failures = 0;

    int m_sh_en[4], m_sh_x[4], m_sh_y[4], m_sh_icon[4];
    int m_act_en[4], m_act_x[4], m_act_y[4], m_act_icon[4];

    icon_fetch_scheduler dut (
        .clk(clk), .rst(rst), .pix_req(pix_req), .pix_ready(pix_ready),
        .x(x), .y(y), .bg_rgb(bg_rgb), .out_valid(out_valid),
        .red(red), .green(green), .blue(blue), .out_hit(out_hit), .out_slot(out_slot),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_icon(cfg_icon), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a scrambled pattern, with icon 7 pixel (0,0) stored as magenta.
    function automatic logic [7:0] rom_byte(input int a);
        if (a == 48384 || a == 48386) return 8'hFF;
        if (a == 48385) return 8'h00;
        return 8'((a * 7) ^ (a >> 5) ^ 8'h5A);
    endfunction

    always @(posedge clk) if (rom_rd) rom_data <= rom_byte(int'(rom_addr));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < 4; s++) begin
            m_sh_en[s] = 0; m_sh_x[s] = 0; m_sh_y[s] = 0; m_sh_icon[s] = 0;
            m_act_en[s] = 0; m_act_x[s] = 0; m_act_y[s] = 0; m_act_icon[s] = 0;
        end
    endtask

    task automatic modelCopy();
        for (int s = 0; s < 4; s++) begin
            m_act_en[s] = m_sh_en[s]; m_act_x[s] = m_sh_x[s];
            m_act_y[s] = m_sh_y[s]; m_act_icon[s] = m_sh_icon[s];
        end
    endtask

    // One config cycle while the DUT is idle; a commit here copies the pre-write shadow.
    task automatic cfgOp(input bit we, input bit commit, input int slot, input int en,
                         input int cx, input int cy, input int icon);
        cfg_we = we; cfg_commit = commit; cfg_slot = 2'(slot); cfg_en = (en != 0);
        cfg_x = 10'(cx); cfg_y = 10'(cy); cfg_icon = 3'(icon);
        if (commit) modelCopy();
        if (we) begin
            m_sh_en[slot] = en; m_sh_x[slot] = cx; m_sh_y[slot] = cy; m_sh_icon[slot] = icon;
        end
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    // One pixel request observed over cycles 1..10 after the transfer cycle.
    task automatic applyStimulus(input string tag, input int px, input int py, input logic [23:0] bg,
                                 input bit commit_now, input bit mid_cfg, input int ms, input int mx,
                                 input int my, input int mic);
        int w, e_hit, e_slot, e_base;
        logic [23:0] e_rgb, rgb;
        logic [10:0] vmask, rmask, readymask, pmask;
        logic [47:0] addrs, e_addrs;
        logic ohit;
        logic [1:0] oslot;
        w = 0;
        while (!pix_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_ready_in"}, 64'(pix_ready), 64'd1);
        pix_req = 1'b1; x = 10'(px); y = 10'(py); bg_rgb = bg; cfg_commit = commit_now;
        if (commit_now) modelCopy();
        e_hit = 0; e_slot = 0; e_base = 0;
        for (int s = 0; s < 4; s++) begin
            if (e_hit == 0 && m_act_en[s] != 0 && px >= m_act_x[s] && px < m_act_x[s] + 48
                && py >= m_act_y[s] && py < m_act_y[s] + 48) begin
                e_hit = 1;
                e_slot = s;
                e_base = (m_act_icon[s] * 6912 + ((py - m_act_y[s]) * 48 + (px - m_act_x[s])) * 3) % 65536;
            end
        end
        e_rgb = e_hit ? {rom_byte(e_base), rom_byte(e_base + 1), rom_byte(e_base + 2)} : bg;
        e_addrs = {16'(e_base), 16'(e_base + 1), 16'(e_base + 2)};
`ifdef TRANSPARENCY_EN
        if (e_hit != 0 && e_rgb == 24'hFF00FF) begin
            e_rgb = bg;
            e_hit = 0;
            e_slot = e_slot + 4;
        end
`endif
        vmask = '0; rmask = '0; readymask = '0; pmask = '0; addrs = '0;
        rgb = 'x; ohit = 1'bx; oslot = 'x;
        @(negedge clk);
        pix_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            vmask[k] = out_valid; rmask[k] = rom_rd; readymask[k] = pix_ready; pmask[k] = cfg_pending;
            if (rom_rd) addrs = {addrs[31:0], rom_addr};
            if (out_valid) begin
                rgb = {red, green, blue}; ohit = out_hit; oslot = out_slot;
            end
            if (mid_cfg && k == 3) begin
                cfg_we = 1'b1; cfg_slot = 2'(ms); cfg_en = 1'b1; cfg_x = 10'(mx); cfg_y = 10'(my);
                cfg_icon = 3'(mic); cfg_commit = 1'b1;
            end else begin
                cfg_we = 1'b0; cfg_commit = 1'b0;
            end
            @(negedge clk);
        end
        if (mid_cfg) begin
            m_sh_en[ms] = 1; m_sh_x[ms] = mx; m_sh_y[ms] = my; m_sh_icon[ms] = mic;
            modelCopy();
        end
        // A transparent hit still fetches, so timing follows the fetch path.
        if (e_hit != 0 || e_slot >= 4) begin
            checkOutput({tag, "_valid_cycle"}, 64'(vmask), 64'h040);
            checkOutput({tag, "_rd_cycles"}, 64'(rmask), 64'h01C);
            checkOutput({tag, "_ready_cycles"}, 64'(readymask), 64'h780);
            checkOutput({tag, "_rom_addrs"}, 64'(addrs), 64'(e_addrs));
        end else begin
            checkOutput({tag, "_valid_cycle"}, 64'(vmask), 64'h004);
            checkOutput({tag, "_rd_cycles"}, 64'(rmask), 64'h000);
            checkOutput({tag, "_ready_cycles"}, 64'(readymask), 64'h7F8);
        end
        if (e_slot >= 4) e_slot = e_slot - 4;
        checkOutput({tag, "_pending"}, 64'(pmask), mid_cfg ? 64'h0F0 : 64'h000);
        checkOutput({tag, "_rgb"}, 64'(rgb), 64'(e_rgb));
        checkOutput({tag, "_hit"}, 64'(ohit), 64'(e_hit));
        checkOutput({tag, "_slot"}, 64'(oslot), 64'(e_slot));
    endtask

    initial begin
        int vcount, t, px, py;
        rst = 1'b1; pix_req = 1'b0; x = '0; y = '0; bg_rgb = '0;
        cfg_we = 1'b0; cfg_slot = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0; cfg_icon = '0; cfg_commit = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_outputs",
                    64'({out_valid, out_hit, out_slot, red, green, blue, rom_rd, rom_addr, cfg_pending, pix_ready}),
                    64'd1);

        applyStimulus("miss_noconfig", 5, 5, 24'h102030, 0, 0, 0, 0, 0, 0);

        cfgOp(1, 0, 1, 1, 100, 50, 2);
        cfgOp(0, 1, 0, 0, 0, 0, 0);
        applyStimulus("slot1_icon2", 101, 52, 24'h0A0B0C, 0, 0, 0, 0, 0, 0);

        cfgOp(1, 0, 0, 1, 200, 100, 3);
        cfgOp(1, 0, 2, 1, 220, 120, 5);
        cfgOp(0, 1, 0, 0, 0, 0, 0);
        applyStimulus("overlap_prio", 230, 130, 24'h111111, 0, 0, 0, 0, 0, 0);
        applyStimulus("edge_x48_miss", 248, 110, 24'h222222, 0, 0, 0, 0, 0, 0);
        applyStimulus("edge_x47_hit", 247, 110, 24'h333333, 0, 0, 0, 0, 0, 0);
        applyStimulus("slot2_corner", 267, 167, 24'h444444, 0, 0, 0, 0, 0, 0);
        applyStimulus("slot2_y48_miss", 230, 168, 24'h555555, 0, 0, 0, 0, 0, 0);

        applyStimulus("midfetch_cfg_old", 101, 52, 24'h666666, 0, 1, 1, 101, 52, 4);
        applyStimulus("midfetch_cfg_new", 101, 52, 24'h777777, 0, 0, 0, 0, 0, 0);

        cfgOp(1, 1, 3, 1, 600, 600, 1);
        applyStimulus("copy_prewrite", 600, 600, 24'h888888, 0, 0, 0, 0, 0, 0);
        cfgOp(0, 1, 0, 0, 0, 0, 0);
        applyStimulus("copy_later", 600, 600, 24'h999999, 0, 0, 0, 0, 0, 0);

        cfgOp(1, 0, 3, 1, 700, 700, 6);
        applyStimulus("commit_at_xfer", 701, 702, 24'hAAAAAA, 1, 0, 0, 0, 0, 0);

        cfgOp(1, 1, 2, 1, 10, 10, 7);
        cfgOp(0, 1, 0, 0, 0, 0, 0);
        applyStimulus("magenta", 10, 10, 24'h123456, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            cfgOp(1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)));
            t = int'($urandom_range(0, 3));
            px = (m_act_x[t] + int'($urandom_range(0, 55)) - 4) & 1023;
            py = (m_act_y[t] + int'($urandom_range(0, 55)) - 4) & 1023;
            applyStimulus($sformatf("rand%0d", i), px, py, 24'($urandom),
                          $urandom_range(0, 3) == 0, 0, 0, 0, 0, 0);
        end

        cfgOp(1, 1, 1, 1, 100, 50, 2);
        cfgOp(0, 1, 0, 0, 0, 0, 0);
        pix_req = 1'b1; x = 10'd101; y = 10'd52; bg_rgb = 24'h0F0E0D;
        @(negedge clk);
        pix_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_rd", 64'(rom_rd), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_rd_drop", 64'({rom_rd, out_valid, pix_ready}), 64'b001);
        rst = 1'b0;
        modelReset();
        vcount = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) vcount++;
            @(negedge clk);
        end
        checkOutput("rst_no_valid", 64'(vcount), 64'd0);
        checkOutput("rst_pending", 64'(cfg_pending), 64'd0);
        applyStimulus("rst_slots_off", 101, 52, 24'hABCDEF, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icon_fetch_scheduler.md
# icon_fetch_scheduler

Sequences pixel lookups into the shared byte-wide icon bitmap ROM for the POS display. For each pixel request (x, y), it hit-tests up to NUM_SLOTS configurable on-screen icon slots, then issues three consecutive byte reads (R, G, B) to the ROM. It returns one RGB triple per request through a ready/valid handshake. It sits between the display timing logic and the bitmap ROM, and lets the menu logic place and swap product icons at run time.

## Interface
- NUM_SLOTS, 4: number of on-screen icon slots; slot 0 has highest priority.
- NUM_ICONS, 8: number of 48x48 icons stored back to back in the ROM.
- ICON_W, 48: icon width in pixels.
- ICON_H, 48: icon height in pixels.
- ROM_AW, 16: ROM byte-address width; must satisfy 2^ROM_AW >= NUM_ICONS*ICON_W*ICON_H*3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_req  in  1  pixel lookup request
- pix_ready  out  1  high only in IDLE; a transfer occurs when pix_req && pix_ready
- x, y  in  10 each  display coordinates, captured on transfer
- bg_rgb  in  24  background colour {R,G,B}, sampled in CALC
- out_valid  out  1  one-cycle pulse; red/green/blue/out_hit/out_slot are valid
- red, green, blue  out  8 each  result colour; held until the next out_valid
- out_hit  out  1  pixel came from an icon
- out_slot  out  $clog2(NUM_SLOTS)  winning slot (0 on miss)
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ROM_AW  ROM byte address
- rom_data  in  8  ROM byte; valid the cycle after rom_rd/rom_addr
- cfg_we  in  1  write shadow slot registers
- cfg_slot  in  $clog2(NUM_SLOTS)  slot index
- cfg_en  in  1  slot enable
- cfg_x, cfg_y  in  10 each  slot top-left corner
- cfg_icon  in  $clog2(NUM_ICONS)  icon index
- cfg_commit  in  1  request a shadow-to-active copy
- cfg_pending  out  1  commit requested, not yet applied

## Operation
- FSM states: IDLE, CALC, RD_R, RD_G, RD_B, LAST, DONE.
- IDLE: pix_ready=1. On transfer, capture x and y, then go to CALC.
- CALC: run the hit-test on the captured coordinates using the active slot registers.
  - Slot s hits if en_s && x>=sx_s && x<sx_s+ICON_W && y>=sy_s && y<sy_s+ICON_H.
  - Compare at 11 bits so the sums do not wrap.
  - The lowest-index hit wins.
  - On a hit, compute base = icon_s*ICON_W*ICON_H*3 + ((y-sy_s)*ICON_W + (x-sx_s))*3, truncated to ROM_AW, and go to RD_R.
  - On a miss, load red/green/blue from bg_rgb, set out_hit=0, and go to DONE.
- RD_R, RD_G, RD_B: rom_rd=1 with rom_addr = base, base+1, base+2 respectively. rom_rd=0 in every other state.
- Captures: red is taken from rom_data in RD_G, green in RD_B, and blue in LAST. LAST then goes to DONE.
- DONE: out_valid=1 for one cycle, then go to IDLE.
- Config writes:
  - A cfg_we write lands in the shadow bank in any cycle.
  - cfg_commit sets pending. On the first cycle that is IDLE with pending=1 (including the commit cycle itself), the active bank is loaded from the shadow bank at the clock edge and pending is cleared.
  - A cfg_we and a copy in the same cycle: the copy uses the pre-write shadow contents.
  - A request accepted in the same IDLE cycle as the copy is hit-tested against the new configuration.
- Reset values:
  - FSM in IDLE; pix_ready=1.
  - out_valid, out_hit, out_slot, red/green/blue, rom_rd and rom_addr all 0.
  - All shadow and active slots disabled with zeroed fields; pending=0.
- rst mid-fetch: the fetch is abandoned and no out_valid is produced. rom_rd drops in the cycle after rst is sampled.

## Timing
- Transfer in cycle 0. CALC in cycle 1.
- Hit: rom_rd high in cycles 2–4, out_valid in cycle 6, ready again in cycle 7.
- Miss: out_valid in cycle 2, ready in cycle 3.
- Outputs are registered; there is no combinational path from pix_req, x or y to any output except none. pix_ready depends on state only.
- Maximum throughput: one hit per 7 cycles, one miss per 3 cycles.

## Configuration
- TRANSPARENCY_EN defined: on a hit whose fetched RGB equals 24'hFF00FF, red/green/blue take bg_rgb and out_hit=0. out_slot still reports the slot and latency is unchanged.
- TRANSPARENCY_EN undefined: magenta is passed through as an ordinary colour with out_hit=1.

## Test plan
- Reset, no config, request (5,5), bg_rgb=24'h102030 -> out_valid in cycle 2, RGB=10/20/30, out_hit=0, rom_rd never asserted.
- Slot 1 at (100,50) with icon 2, committed; request (101,52) -> rom_addr=13824+((2*48+1)*3)=14115,14116,14117 in cycles 2–4. RGB equals the ROM bytes, out_slot=1, out_valid in cycle 6.
- Slots 0 and 2 overlapping, both enabled; request inside the overlap -> out_slot=0. Boundary x=sx+48 -> miss; x=sx+47 -> hit.
- cfg_we and cfg_commit during a fetch -> the in-flight result uses the old config, cfg_pending=1 until the next IDLE; the following request uses the new config.
- rst asserted in RD_G -> no out_valid, pix_ready=1 the next cycle, all slots disabled.
- With TRANSPARENCY_EN, ROM bytes FF,00,FF -> RGB=bg_rgb, out_hit=0.
